// File: rtl/clock_gate.sv
// Emulation clock-control unit: glitch-free gated DUT / FF-scan / RAM-scan clocks,
// pause flag, executed-cycle counter and single-step countdown.
`timescale 1ns/1ps

module clock_gate_cell (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    // Transparent while clk is low, so an enable change during the high phase
    // only reaches the output from the next rising edge.
    always_latch begin
        if (!resetn) begin
            en_lat <= 1'b0;
        end else if (!clk) begin
            en_lat <= en;
        end
    end

    assign gclk = clk & en_lat;

endmodule

module clock_gate #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             trig,
    input  logic             do_pause,
    input  logic             do_resume,
    input  logic             dut_stall,
    input  logic             ff_scan,
    input  logic             ram_scan,
    input  logic             count_write,
    input  logic [CNT_W-1:0] count_wdata,
    input  logic             step_write,
    input  logic [CNT_W-1:0] step_wdata,
    output logic             pause,
    output logic             run_en,
    output logic             dut_clk,
    output logic             ff_clk,
    output logic             ram_clk,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] step,
    output logic             step_trig
);

    localparam int NUM_GATES = 3;

    logic             pause_reg;
    logic             pause_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] step_reg;
    logic [CNT_W-1:0] step_next;
    logic [NUM_GATES-1:0] gate_en;
    logic [NUM_GATES-1:0] gate_clk;

    assign run_en = !pause_reg && !dut_stall;

    always_comb begin
        count_next = count_reg;
        if (count_write) begin
            count_next = count_wdata;
        end else if (run_en) begin
            count_next = count_reg + 1'b1;
        end
    end

    // A zero step count is idle and never decrements or re-fires the trigger.
    always_comb begin
        step_next = step_reg;
        if (step_write) begin
            step_next = step_wdata;
        end else if (step_reg == '0) begin
            step_next = '0;
        end else if (run_en) begin
            step_next = step_reg - 1'b1;
        end
    end

    assign step_trig = (step_reg != '0) && (step_next == '0);

    always_comb begin
        pause_next = pause_reg;
        if (trig || step_trig || do_pause) begin
            pause_next = 1'b1;
        end else if (do_resume) begin
            pause_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pause_reg <= 1'b0;
            count_reg <= '0;
            step_reg  <= '0;
        end else begin
            pause_reg <= pause_next;
            count_reg <= count_next;
            step_reg  <= step_next;
        end
    end

    assign gate_en[0] = run_en;
    assign gate_en[1] = run_en || ff_scan;
    assign gate_en[2] = run_en || ram_scan;

    generate
        for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
            clock_gate_cell u_cell (
                .clk    (clk),
                .resetn (resetn),
                .en     (gate_en[gi]),
                .gclk   (gate_clk[gi])
            );
        end
    endgenerate

    assign dut_clk = gate_clk[0];
    assign ff_clk  = gate_clk[1];
    assign ram_clk = gate_clk[2];
    assign pause   = pause_reg;
    assign count   = count_reg;
    assign step    = step_reg;

endmodule

// File: tb/tb_clock_gate.sv
// Directed bench for clock_gate: expectations are queued per step and drained
// against DUT outputs; gated-clock pulse widths are checked for glitches.
`timescale 1ns/1ps

module tb_clock_gate;

    localparam int CNT_W = 64;

    logic             clk;
    logic             resetn;
    logic             trig;
    logic             do_pause;
    logic             do_resume;
    logic             dut_stall;
    logic             ff_scan;
    logic             ram_scan;
    logic             count_write;
    logic [CNT_W-1:0] count_wdata;
    logic             step_write;
    logic [CNT_W-1:0] step_wdata;
    logic             pause;
    logic             run_en;
    logic             dut_clk;
    logic             ff_clk;
    logic             ram_clk;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] step;
    logic             step_trig;

    clock_gate #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .trig        (trig),
        .do_pause    (do_pause),
        .do_resume   (do_resume),
        .dut_stall   (dut_stall),
        .ff_scan     (ff_scan),
        .ram_scan    (ram_scan),
        .count_write (count_write),
        .count_wdata (count_wdata),
        .step_write  (step_write),
        .step_wdata  (step_wdata),
        .pause       (pause),
        .run_en      (run_en),
        .dut_clk     (dut_clk),
        .ff_clk      (ff_clk),
        .ram_clk     (ram_clk),
        .count       (count),
        .step        (step),
        .step_trig   (step_trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Gated clock monitor: pulse counts and high-phase widths.
    logic [2:0] gck;
    logic [2:0] g_prev;
    longint     rise_t [3];
    bit         seen   [3];
    int         pulses [3];
    int         base   [3];
    int         width_q [$];
    int         width_id_q [$];
    int         trig_cnt = 0;

    assign gck = {ram_clk, ff_clk, dut_clk};

    initial begin
        for (int i = 0; i < 3; i++) begin
            pulses[i] = 0;
            seen[i]   = 1'b0;
            rise_t[i] = 0;
        end
    end

    always @(gck) begin
        for (int i = 0; i < 3; i++) begin
            if (g_prev[i] !== 1'b1 && gck[i] === 1'b1) begin
                rise_t[i] = $time;
                seen[i]   = 1'b1;
                pulses[i] = pulses[i] + 1;
            end else if (g_prev[i] === 1'b1 && gck[i] === 1'b0 && seen[i]) begin
                width_q.push_back(int'($time - rise_t[i]));
                width_id_q.push_back(i);
            end
        end
        g_prev = gck;
    end

    always @(negedge clk) begin
        if (step_trig === 1'b1) trig_cnt = trig_cnt + 1;
    end

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t sb_q [$];

    task automatic want(input string tag, input logic [63:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic mark();
        for (int i = 0; i < 3; i++) base[i] = pulses[i];
    endtask

    task automatic drain(input string step_name);
        sb_t         e;
        logic [63:0] obs;
        int          w;
        int          wid;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.tag)
                "count":     obs = count;
                "step":      obs = step;
                "pause":     obs = {63'd0, pause};
                "run_en":    obs = {63'd0, run_en};
                "step_trig": obs = {63'd0, step_trig};
                "dut_n":     obs = 64'(pulses[0] - base[0]);
                "ff_n":      obs = 64'(pulses[1] - base[1]);
                "ram_n":     obs = 64'(pulses[2] - base[2]);
                "trig_seen": obs = 64'(trig_cnt);
                default:     obs = 'x;
            endcase
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s/%s observed=%0h expected=%0h", step_name, e.tag, obs, e.exp);
            end
            $display("[%0t] %s %s observed=%0h expected=%0h", $time, step_name, e.tag, obs, e.exp);
        end
        while (width_q.size() > 0) begin
            w   = width_q.pop_front();
            wid = width_id_q.pop_front();
            checks++;
            assert (w === 5) else begin
                failures++;
                $error("FAIL %s/pulse_width clk%0d observed=%0d expected=5", step_name, wid, w);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn      = 1'b0;
        trig        = 1'b0;
        do_pause    = 1'b0;
        do_resume   = 1'b0;
        dut_stall   = 1'b0;
        ff_scan     = 1'b0;
        ram_scan    = 1'b0;
        count_write = 1'b0;
        count_wdata = '0;
        step_write  = 1'b0;
        step_wdata  = '0;
        mark();

        // Reset held with the clock running: nothing moves.
        tick(3);
        want("count", 0); want("step", 0); want("pause", 0); want("dut_n", 0);
        drain("reset");

        // Release and run 9 cycles.
        resetn = 1'b1;
        mark();
        tick(9);
        want("count", 9); want("dut_n", 9); want("pause", 0); want("step", 0);
        want("trig_seen", 0);
        drain("free_run");

        // Load a 5-cycle step on the 10th run cycle.
        step_write = 1'b1;
        step_wdata = 64'd5;
        tick();
        step_write = 1'b0;
        want("count", 10); want("step", 5); want("dut_n", 10);
        drain("step_load");

        tick(3);
        want("step", 2); want("step_trig", 0); want("count", 13);
        drain("step_mid");
        tick();
        want("step", 1); want("step_trig", 1); want("pause", 0); want("count", 14);
        drain("step_last");
        tick();
        want("step", 0); want("pause", 1); want("count", 15); want("step_trig", 0);
        want("dut_n", 15); want("trig_seen", 1);
        drain("step_done");

        mark();
        tick(3);
        want("count", 15); want("dut_n", 0); want("run_en", 0);
        drain("paused_hold");

        // FF scan while paused.
        mark();
        ff_scan = 1'b1;
        tick(8);
        ff_scan = 1'b0;
        tick(2);
        want("ff_n", 8); want("dut_n", 0); want("ram_n", 0); want("count", 15);
        drain("ff_scan");

        // Resume.
        do_resume = 1'b1;
        tick();
        do_resume = 1'b0;
        want("pause", 0); want("count", 15);
        drain("resume");
        mark();
        tick(2);
        want("count", 17); want("dut_n", 2); want("ram_n", 2);
        drain("resumed_run");

        // Stall while running, with a step loaded alongside it.
        mark();
        dut_stall  = 1'b1;
        step_write = 1'b1;
        step_wdata = 64'd10;
        tick();
        step_write = 1'b0;
        tick(2);
        want("count", 17); want("step", 10); want("pause", 0); want("dut_n", 0);
        want("run_en", 0);
        drain("stall");
        #2;
        dut_stall = 1'b0;
        tick(2);
        want("count", 19); want("step", 8); want("dut_n", 2);
        drain("unstall");

        // Pause and resume in the same cycle: pause wins.
        do_pause  = 1'b1;
        do_resume = 1'b1;
        tick();
        do_pause  = 1'b0;
        do_resume = 1'b0;
        want("pause", 1); want("count", 20); want("step", 7);
        drain("pause_vs_resume");

        // Counter wrap.
        count_write = 1'b1;
        count_wdata = {CNT_W{1'b1}};
        tick();
        count_write = 1'b0;
        want("count", 64'hFFFF_FFFF_FFFF_FFFF);
        drain("count_load");
        do_resume = 1'b1;
        tick();
        do_resume = 1'b0;
        want("pause", 0); want("count", 64'hFFFF_FFFF_FFFF_FFFF); want("step", 7);
        drain("wrap_resume");
        tick();
        want("count", 0); want("step", 6);
        drain("count_wrap");

        // DUT trigger pauses.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        want("pause", 1); want("count", 1); want("step", 5);
        drain("dut_trig");

        // Step load while paused holds; writing 0 over nonzero fires the trigger.
        step_write = 1'b1;
        step_wdata = 64'd3;
        tick();
        step_write = 1'b0;
        tick();
        want("step", 3); want("step_trig", 0);
        drain("step_hold_paused");
        step_write = 1'b1;
        step_wdata = 64'd0;
        #1;
        want("step_trig", 1);
        drain("step_zero_write");
        tick();
        step_write = 1'b0;
        want("step", 0); want("pause", 1); want("step_trig", 0);
        drain("step_zeroed");

        // Asynchronous reset while paused with step=7.
        step_write = 1'b1;
        step_wdata = 64'd7;
        tick();
        step_write = 1'b0;
        want("step", 7); want("pause", 1); want("count", 1);
        drain("pre_reset");
        #2;
        resetn = 1'b0;
        #1;
        want("pause", 0); want("count", 0); want("step", 0);
        drain("async_reset");
        mark();
        tick(2);
        want("dut_n", 0); want("count", 0);
        drain("reset_held");
        resetn = 1'b1;
        mark();
        tick(4);
        want("count", 4); want("dut_n", 4); want("pause", 0);
        drain("post_reset_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_gate.md
Name: clock_gate

Overview:
- Emulation clock-control unit that sits between the free-running emulator clock and the DUT wrapper.
- Produces three glitch-free gated clocks:
  - DUT functional clock.
  - Flip-flop scan-chain clock.
  - RAM scan-chain clock.
- Owns the pause flag, a 64-bit executed-cycle counter and a single-step countdown that pauses the DUT after N cycles.

Parameters:
- CNT_W, 64, width of the cycle counter and the step counter.

Ports:
- clk  in  1  emulator clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- trig  in  1  DUT trigger; requests pause.
- do_pause  in  1  host pause request (single-cycle pulse or level).
- do_resume  in  1  host resume request.
- dut_stall  in  1  DUT wrapper stall; freezes DUT clocks while high.
- ff_scan  in  1  FF scan enable; forces ff_clk running.
- ram_scan  in  1  RAM scan enable; forces ram_clk running.
- count_write  in  1  load count.
- count_wdata  in  CNT_W  count load value.
- step_write  in  1  load step.
- step_wdata  in  CNT_W  step load value.
- pause  out  1  registered pause flag.
- run_en  out  1  pause==0 && dut_stall==0.
- dut_clk  out  1  clk gated by run_en.
- ff_clk  out  1  clk gated by (run_en || ff_scan).
- ram_clk  out  1  clk gated by (run_en || ram_scan).
- count  out  CNT_W  DUT cycles executed.
- step  out  CNT_W  remaining step cycles.
- step_trig  out  1  step countdown reaches zero this cycle.

Behaviour:
- Gate cell (instantiated 3x):
  - Enable latch is transparent while clk is low and holds while clk is high.
  - Gated clock = clk AND latched enable.
  - An enable change during clk high takes effect from the next rising edge; no glitch or runt pulse is permitted.
  - Latches reset to 0 asynchronously.
- run_en: combinational, = !pause && !dut_stall.
- Clock enables:
  - dut_clk enable = run_en.
  - ff_clk enable = run_en || ff_scan.
  - ram_clk enable = run_en || ram_scan.
- Relationship between enable and clock edge: the rising edge of clk at which run_en is sampled 1 is the edge delivered on dut_clk. Counter updates on that same clk edge.
- count:
  - Reset 0.
  - Priority: count_write loads count_wdata; else if run_en then count+1, modulo 2^CNT_W, wraps to 0; else hold.
- step_next (combinational):
  - step_write → step_wdata.
  - else step==0 → 0.
  - else run_en → step-1.
  - else step.
- step: reset 0; step <= step_next every cycle.
- step_trig: combinational, = (step!=0) && (step_next==0).
  - Asserts in the cycle the last step cycle executes.
  - Also asserts when step_write loads 0 over a nonzero step.
  - Never asserts while step==0.
- pause:
  - Reset 0.
  - Set if trig || step_trig || do_pause; else cleared if do_resume; else hold.
  - A set source wins over do_resume in the same cycle.
  - Takes effect on dut_clk from the edge after it registers. The cycle where step_trig fires is still executed, so exactly N DUT cycles run.
- Reset mid-operation: pause, count, step and the gate latches clear immediately, asynchronously. After deassertion the DUT clock runs unless dut_stall is high.
- Scan: with pause=1, ff_scan=1 keeps ff_clk toggling while dut_clk stays low and count does not advance. Same for ram_scan with ram_clk.

Test Plan:
- Reset release with dut_stall=0 for 10 clks → dut_clk pulses 10 times, count=10, pause=0, step=0, step_trig never asserted.
- step_write with step_wdata=5 at count=10 → step_trig high exactly in the 5th run cycle, pause=1 next cycle, count=15, dut_clk stops.
- pause=1, then ff_scan=1 for 8 clks → ff_clk 8 pulses, dut_clk and ram_clk 0 pulses, count unchanged. Then do_resume → dut_clk resumes, count advances.
- dut_stall high for 3 cycles while running → no dut_clk pulses, count and step frozen, pause stays 0. Gated clocks glitch-free when stall toggles mid-high-phase.
- Same cycle: do_pause=1 and do_resume=1 → pause=1. Also count_write with count_wdata=2^64-1 → count=2^64-1, then wraps to 0 on the next run cycle.
- Assert resetn low while paused with step=7 → pause=0, count=0, step=0 immediately, without waiting for a clock edge.
